// File: rtl/aes_pkg.sv
// Shared AES types: FSM state encoding, state geometry and a byte-sliced view
// of the 128-bit state. Packed index 15 is byte 0, the MSB in FIPS-197 order.
package aes_pkg;

  localparam int AES_STATE_W   = 128;
  localparam int AES_NUM_BYTES = 16;
  localparam int AES_NUM_COLS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  typedef logic [AES_NUM_BYTES-1:0][7:0] aes_bytes_t;

endpackage

// File: rtl/sbox_unit.sv
// Combinational forward AES S-box (FIPS-197 table) implemented as a 256-entry LUT.
module sbox_unit (
  input  logic [7:0] inputByte,
  output logic [7:0] byteSOut
);

  localparam logic [7:0] SBOX_LUT [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign byteSOut = SBOX_LUT[inputByte];

endmodule

// File: rtl/aes_sub_bytes.sv
// AES-128 forward SubBytes: column-serial (4 S-boxes, 4 cycles) by default;
// define AES_SUBBYTES_WIDE_EN for a single-cycle 16-S-box build.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

`ifdef AES_SUBBYTES_WIDE_EN
  localparam int NUM_SBOX = AES_NUM_BYTES;
`else
  localparam int NUM_SBOX = AES_NUM_BYTES / AES_NUM_COLS;
`endif

  aes_fsm_e   state_q, state_d;
  aes_bytes_t data_q, data_d;
`ifndef AES_SUBBYTES_WIDE_EN
  logic [1:0] col_q, col_d;
`endif

  logic [7:0] sb_in  [NUM_SBOX];
  logic [7:0] sb_out [NUM_SBOX];

  // Byte 4*col+k of the state sits at packed index 15-(4*col+k), i.e. ~{col,k}.
  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
`ifdef AES_SUBBYTES_WIDE_EN
    assign sb_in[k] = data_q[k];
`else
    assign sb_in[k] = data_q[~{col_q, 2'(k)}];
`endif
    sbox_unit u_sbox (
      .inputByte (sb_in[k]),
      .byteSOut  (sb_out[k])
    );
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
`ifndef AES_SUBBYTES_WIDE_EN
    col_d   = col_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = state_in;
`ifndef AES_SUBBYTES_WIDE_EN
          col_d   = 2'd0;
`endif
          state_d = SUB;
        end
      end
      SUB: begin
`ifdef AES_SUBBYTES_WIDE_EN
        for (int k = 0; k < NUM_SBOX; k++) data_d[k] = sb_out[k];
        state_d = DONE;
`else
        for (int k = 0; k < NUM_SBOX; k++) data_d[~{col_q, 2'(k)}] = sb_out[k];
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value. The data register is reset too, so state_out
  // reads zero after reset instead of leaking a discarded in-flight state.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
`ifndef AES_SUBBYTES_WIDE_EN
      col_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
`ifndef AES_SUBBYTES_WIDE_EN
      col_q   <= col_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SUB) || (state_q == DONE);
  assign state_out = data_q;

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Self-checking bench for aes_sub_bytes: scoreboard of expected states, an
// independent GF(2^8) S-box model, latency/backpressure/reset/sweep scenarios.
module tb_aes_sub_bytes;

`ifdef AES_SUBBYTES_WIDE_EN
  localparam int LAT    = 1;
  localparam int PERIOD = 3;
`else
  localparam int LAT    = 4;
  localparam int PERIOD = 6;
`endif

  logic         clk;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  aes_sub_bytes dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_mon  = 0;
  logic ov_prev = 1'b0;
  logic [127:0] exp_q [$];
  logic [7:0]   ref_sbox [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_ref();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_model(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = ref_sbox[v[127-8*i -: 8]];
    return r;
  endfunction

  // Monitor: samples on the falling edge, between driver updates.
  always @(negedge clk) begin
    if (!n_rst) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_mon = cyc + 1;
      if (out_valid && !ov_prev) check("latency", 128'(cyc - acc_mon), 128'(LAT));
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", state_out, 128'hx);
        else check("data", state_out, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [127:0] v, input logic [127:0] e, output int acc_c);
    int n = 0;
    acc_c = -1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("send_ready", 128'(in_ready), 128'd1);
      return;
    end
    in_valid = 1'b1;
    state_in = v;
    exp_q.push_back(e);
    @(posedge clk); #1;
    acc_c    = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin
    int acc1, acc2, n;
    logic [127:0] v;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    n_rst     = 1'b0;
    build_ref();

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_state_out", state_out,       128'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(FIPS_IN, FIPS_OUT, acc1);
    wait_idle();
    send({16{8'h00}}, {16{8'h63}}, acc1);
    wait_idle();
    send({16{8'h53}}, {16{8'hed}}, acc1);
    wait_idle();
    send({16{8'hff}}, {16{8'h16}}, acc1);
    wait_idle();

    // Backpressure: stall DONE, poke in_valid, then release.
    out_ready = 1'b0;
    send(FIPS_IN, FIPS_OUT, acc1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_done", 128'(out_valid), 128'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_data",     state_out,         FIPS_OUT);
      check("bp_valid",    128'(out_valid),   128'd1);
      check("bp_in_ready", 128'(in_ready),    128'd0);
      in_valid = (i >= 2 && i < 6);
      state_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready",  128'(in_ready),  128'd1);
    check("rel_out_valid", 128'(out_valid), 128'd0);
    check("rel_sb_empty",  128'(exp_q.size()), 128'd0);

    // Back-to-back accepts with out_ready held high.
    v = 128'h00112233445566778899aabbccddeeff;
    send(v, sub_model(v), acc1);
    send(~v, sub_model(~v), acc2);
    check("b2b_period", 128'(acc2 - acc1), 128'(PERIOD));
    wait_idle();

    // Reset mid-operation after E2.
    out_ready = 1'b0;
    send(FIPS_IN, FIPS_OUT, acc1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    exp_q.delete();
    check("mrst_state_out", state_out,       128'd0);
    check("mrst_out_valid", 128'(out_valid), 128'd0);
    check("mrst_in_ready",  128'(in_ready),  128'd1);
    check("mrst_busy",      128'(busy),      128'd0);
    repeat (6) @(posedge clk);
    #1;
    check("mrst_no_output", 128'(out_valid), 128'd0);
    out_ready = 1'b1;
    send(FIPS_IN, FIPS_OUT, acc1);
    wait_idle();

    // Exhaustive sweep: every byte value, rotated across lane positions.
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = 8'(16*t + ((i + t) % 16));
      send(v, sub_model(v), acc1);
    end
    wait_idle();

    check("final_sb_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_sub_bytes.md
# aes_sub_bytes

Forward SubBytes layer for the AES-128 encryption datapath. The block accepts a 128-bit state over a valid/ready handshake and substitutes every byte through the forward AES S-box. By default it processes one 32-bit column per cycle, using four S-box instances. It then presents the result on an output valid/ready handshake for ShiftRows.

## Interface
- No parameters; the width is fixed at 128 bits (16 bytes, 4 columns).
- clk  input  1  system clock; all logic is rising-edge.
- n_rst  input  1  reset, synchronous, active-low; sampled on the clk rising edge.
- in_valid  input  1  state_in is valid.
- in_ready  output  1  block can accept a state; high only in IDLE.
- state_in  input  128  state to substitute; byte i = state_in[127-8i -: 8] (byte 0 = MSB, FIPS-197 input order).
- out_valid  output  1  state_out holds a completed result; high only in DONE.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  substituted state, same byte ordering; driven directly from the data register.
- busy  output  1  high in SUB or DONE.

## Operation
- FSM states: IDLE, SUB, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: capture state_in into data register, clear col_cnt to 0, go to SUB.
- SUB
  - Each cycle, bytes 4·col_cnt .. 4·col_cnt+3 of the data register pass through the four S-box instances and are written back in place.
  - col_cnt is 2 bits and increments each cycle.
  - When col_cnt==3, perform the final write-back, go to DONE and let col_cnt wrap to 0.
- DONE
  - out_valid=1.
  - Hold the data register stable until out_ready.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. state_in is not re-sampled after capture.
- out_ready is ignored outside DONE.
- Untouched columns in the data register keep their captured values until they are substituted.
- Reset (n_rst low at an edge, in any state including mid-SUB):
  - State goes to IDLE, col_cnt=0, data register=0.
  - Any in-flight state is discarded and no output is produced.
  - Outputs after the reset edge: in_ready=1, out_valid=0, busy=0, state_out=0.
- S-box: the standard FIPS-197 forward table, e.g. 00→63, 01→7C, 53→ED, FF→16.

## Timing
- Accept edge E0: in_valid & in_ready.
- SUB writes occur at edges E1..E4. out_valid rises after E4, giving a latency of 4 cycles from E0.
- Output handshake at edge Ek (out_valid & out_ready) → IDLE. in_ready is high again in the following cycle.
- Minimum accept-to-accept period: 6 cycles (4 SUB + 1 DONE + 1 IDLE) when out_ready is held high.
- out_ready held low stalls DONE indefinitely, with state_out and out_valid stable.
- All outputs are registered-state decodes; there is no combinational path from inputs to outputs.

## Configuration
- AES_SUBBYTES_WIDE_EN defined:
  - 16 S-box instances; all bytes are substituted at edge E1.
  - SUB lasts 1 cycle, latency is 1 cycle, and the minimum period is 3 cycles.
  - col_cnt is unused.
- Undefined (default): 4 S-box instances and the column-serial behaviour above.
- The handshake, reset and ordering rules are identical in both builds.

## Structure
- Shared package aes_pkg:
  - state enum (IDLE, SUB, DONE);
  - AES_STATE_W=128, AES_NUM_BYTES=16, AES_NUM_COLS=4;
  - a byte-slice typedef for the state.
- Sub-module sbox_unit: combinational forward S-box LUT, input inputByte[7:0], output byteSOut[7:0].
  - Instanced 4× by default, or 16× with AES_SUBBYTES_WIDE_EN.
- Top-level contents: FSM, col_cnt, data register, byte-lane muxing.

## Test plan
- FIPS-197 Appendix B round-1 vector:
  - Stimulus: state_in=128'h193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: state_out=128'hd42711aee0bf98f1b8b45de51e415230, with out_valid exactly 4 cycles after accept (1 cycle in the WIDE build).
- Uniform-byte vectors: all-00 → all-63; all-53 → all-ED; all-FF → all-16.
- Output backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → state_out stays stable, in_ready=0, and a new in_valid is ignored.
  - Release out_ready → IDLE next cycle.
- Back-to-back input with out_ready=1: two states are accepted 6 cycles apart, with results in order and correct.
- Reset mid-operation:
  - Drop n_rst for one edge after E2 → state_out=0, out_valid=0, in_ready=1.
  - A fresh vector afterwards completes correctly.
- Exhaustive S-box sweep: 16 transactions cover bytes 00..FF across all lane positions; the bench checks each lane against a reference S-box model.
